// File: rtl/ahb_key_led_ctrl_pkg.sv
// ahb_key_led_pkg: shared constants for the AHB-Lite key/LED peripheral.
//   - word offsets (HADDR[3:2]) of the four registers
//   - HTRANS encodings and the OKAY response code
package ahb_key_led_pkg;

  localparam logic [1:0] REG_LED_DATA  = 2'd0;
  localparam logic [1:0] REG_KEY_STATE = 2'd1;
  localparam logic [1:0] REG_KEY_EVENT = 2'd2;
  localparam logic [1:0] REG_IRQ_EN    = 2'd3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY = 1'b0;

endpackage

// File: rtl/ahb_key_led_ctrl_if.sv
// ahb_key_led_ctrl_if: AHB-Lite slave-side bundle for the key/LED peripheral.
//   master modport: drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY,
//                   receives HRDATA/HREADYOUT/HRESP
//   slave modport : the reverse
interface ahb_key_led_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_key_led_ctrl_key_debounce.sv
// key_debounce: one active-low key input.
//   clk, rst   : clock, synchronous active-high reset
//   key_raw    : asynchronous raw key (0 = pressed)
//   key_state  : debounced level (1 = pressed)
//   press      : one-cycle pulse, high on the edge where key_state goes 0->1
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_state,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // s is the synchronised key in pressed-high polarity
  assign s      = ~sync2;
  assign accept = (s != key_state) && (cnt == CNT_LAST);
  // press is taken from the same condition that loads key_state so the
  // event register sets on the very edge the debounced level changes
  assign press  = accept & s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      cnt       <= '0;
      key_state <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (s == key_state) begin
        cnt <= '0;
      end else if (accept) begin
        key_state <= s;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ahb_key_led_ctrl.sv
// ahb_key_led_ctrl: AHB-Lite slave with debounced keys and LED outputs.
//   HCLK, HRESET : clock, synchronous active-high reset
//   bus          : AHB-Lite slave modport (zero wait state, always OKAY)
//   FPGA_Key     : raw active-low keys
//   FPGA_LED     : LED drive, 1 = on
//   IRQ          : registered |(KEY_EVENT & IRQ_EN)
// Registers (HADDR[3:2]): 0 LED_DATA RW, 1 KEY_STATE RO, 2 KEY_EVENT W1C,
// 3 IRQ_EN RW.
// Build option KEY_TOGGLE_EN: a press event on key i also toggles LED_DATA[i].
module ahb_key_led_ctrl
  import ahb_key_led_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_key_led_ctrl_if.slave    bus,
  input  logic [NUM_KEYS-1:0]  FPGA_Key,
  output logic [NUM_LEDS-1:0]  FPGA_LED,
  output logic                 IRQ
);

  logic [NUM_KEYS-1:0] key_state, key_press;
  logic [NUM_LEDS-1:0] led_data, led_nxt, toggle_mask;
  logic [NUM_KEYS-1:0] key_event, event_nxt, irq_en;
  logic                addr_valid, wr_q, rd_q;
  logic [1:0]          addr_q;
  logic                wr_led, wr_event, wr_irq_en;
  logic                unused_bus;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk       (HCLK),
      .rst       (HRESET),
      .key_raw   (FPGA_Key[i]),
      .key_state (key_state[i]),
      .press     (key_press[i])
    );
  end

  assign addr_valid = bus.HSEL & bus.HREADY &
                      ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      wr_q <= addr_valid & bus.HWRITE;
      rd_q <= addr_valid & ~bus.HWRITE;
      if (addr_valid) addr_q <= bus.HADDR[3:2];
    end
  end

  assign wr_led    = wr_q && (addr_q == REG_LED_DATA);
  assign wr_event  = wr_q && (addr_q == REG_KEY_EVENT);
  assign wr_irq_en = wr_q && (addr_q == REG_IRQ_EN);

`ifdef KEY_TOGGLE_EN
  localparam int NUM_TOG = (NUM_KEYS < NUM_LEDS) ? NUM_KEYS : NUM_LEDS;
  always_comb begin
    toggle_mask = '0;
    for (int i = 0; i < NUM_TOG; i++) toggle_mask[i] = key_press[i];
  end
`else
  assign toggle_mask = '0;
`endif

  // Toggle applies on top of a same-cycle bus write; a new press event
  // wins over a same-cycle W1C of that bit.
  always_comb begin
    led_nxt   = (wr_led ? bus.HWDATA[NUM_LEDS-1:0] : led_data) ^ toggle_mask;
    event_nxt = (key_event & ~(wr_event ? bus.HWDATA[NUM_KEYS-1:0] : '0)) | key_press;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      led_data  <= '0;
      key_event <= '0;
      irq_en    <= '0;
      IRQ       <= 1'b0;
    end else begin
      led_data  <= led_nxt;
      key_event <= event_nxt;
      if (wr_irq_en) irq_en <= bus.HWDATA[NUM_KEYS-1:0];
      IRQ       <= |(key_event & irq_en);
    end
  end

  always_comb begin
    bus.HRDATA = '0;
    if (rd_q) begin
      case (addr_q)
        REG_LED_DATA:  bus.HRDATA = 32'(led_data);
        REG_KEY_STATE: bus.HRDATA = 32'(key_state);
        REG_KEY_EVENT: bus.HRDATA = 32'(key_event);
        REG_IRQ_EN:    bus.HRDATA = 32'(irq_en);
        default:       bus.HRDATA = '0;
      endcase
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = HRESP_OKAY;
  assign FPGA_LED      = led_data;

  // HSIZE and the undecoded address/data bits have no effect
  assign unused_bus = &{1'b0, bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA};

endmodule

// File: tb/tb_ahb_key_led_ctrl.sv
module tb_ahb_key_led_ctrl;
  import ahb_key_led_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] FPGA_Key;
  logic [3:0] FPGA_LED;
  logic       IRQ;

`ifdef KEY_TOGGLE_EN
  localparam logic [3:0] TOG_MASK = 4'hF;
`else
  localparam logic [3:0] TOG_MASK = 4'h0;
`endif

  ahb_key_led_ctrl_if bus ();

  ahb_key_led_ctrl #(.NUM_KEYS(4), .NUM_LEDS(4), .DEBOUNCE_CYCLES(4)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .bus      (bus.slave),
    .FPGA_Key (FPGA_Key),
    .FPGA_LED (FPGA_LED),
    .IRQ      (IRQ)
  );

  always #5 HCLK = ~HCLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  int          pin_kind_q[$];
  logic [31:0] pin_exp_q[$];
  string       pin_name_q[$];
  logic        rd_dp = 1'b0;
  logic        pin_req = 1'b0;
  logic [3:0]  exp_led;

  logic [31:0] mon_exp, mon_act;
  string       mon_name;
  int          mon_kind;

  // monitor: compares whenever a read data phase or a pin sample is presented
  always @(negedge HCLK) begin
    if (rd_dp) begin
      n_cmp++;
      if (rd_exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: HRDATA 0x%08h with no expected value queued", bus.HRDATA);
      end else begin
        mon_exp  = rd_exp_q.pop_front();
        mon_name = rd_name_q.pop_front();
        if (bus.HRDATA !== mon_exp) begin
          n_bad++;
          $display("FAIL %s: HRDATA got 0x%08h expected 0x%08h", mon_name, bus.HRDATA, mon_exp);
        end
      end
    end
    if (pin_req) begin
      n_cmp++;
      if (pin_exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pin_unexpected: pin sample with no expected value queued");
      end else begin
        mon_kind = pin_kind_q.pop_front();
        mon_exp  = pin_exp_q.pop_front();
        mon_name = pin_name_q.pop_front();
        case (mon_kind)
          0:       mon_act = {28'b0, FPGA_LED};
          1:       mon_act = {31'b0, IRQ};
          2:       mon_act = {31'b0, bus.HREADYOUT};
          default: mon_act = {31'b0, bus.HRESP};
        endcase
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", mon_name, mon_act, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    bus.HADDR  = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic sel = 1'b1, input logic [1:0] trans = HTRANS_NONSEQ);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = 1'b1;
    bus.HADDR  = addr;
    tick();
    idle_bus();
    bus.HWDATA = data;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp,
                          input string name, input logic sel = 1'b1);
    bus.HSEL   = sel;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = 1'b0;
    bus.HADDR  = addr;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    tick();
    idle_bus();
    rd_dp = 1'b1;
    tick();
    rd_dp = 1'b0;
  endtask

  task automatic check_pin(input int kind, input logic [31:0] exp, input string name);
    pin_kind_q.push_back(kind);
    pin_exp_q.push_back(exp);
    pin_name_q.push_back(name);
    pin_req = 1'b1;
    tick();
    pin_req = 1'b0;
  endtask

  task automatic note_press(input logic [3:0] m);
    exp_led = exp_led ^ (m & TOG_MASK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    bus.HSIZE  = 3'b010;
    bus.HWDATA = '0;
    bus.HREADY = 1'b1;
    FPGA_Key   = 4'hF;
    HRESET     = 1'b1;
    tick(3);
    HRESET = 1'b0;

    // reset state
    bus_read(32'h0, 0, "rst_led_data");
    bus_read(32'h4, 0, "rst_key_state");
    bus_read(32'h8, 0, "rst_key_event");
    bus_read(32'hC, 0, "rst_irq_en");
    check_pin(0, 0, "rst_fpga_led");
    check_pin(1, 0, "rst_irq");
    check_pin(2, 1, "hreadyout");
    check_pin(3, 0, "hresp");

    // LED write / read, ignored transfers
    bus_write(32'h0, 32'h5);
    exp_led = 4'h5;
    check_pin(0, 32'h5, "led_pin_after_write");
    bus_read(32'h0, 32'h5, "led_readback");
    bus_write(32'h0, 32'hF, 1'b0);
    bus_write(32'h0, 32'hA, 1'b1, HTRANS_IDLE);
    bus_write(32'h0, 32'hF, 1'b1, HTRANS_BUSY);
    bus_read(32'h0, 32'h5, "led_after_ignored_writes");
    bus_read(32'h0, 32'h0, "read_hsel_low", 1'b0);
    bus_write(32'h4, 32'hF);
    bus_read(32'h4, 32'h0, "key_state_read_only");
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, 32'hF, "irq_en_upper_bits_zero");
    bus_write(32'hC, 32'h0);

    // key 0 press: accepted exactly 2 + 4 edges after the raw edge
    FPGA_Key = 4'b1110;
    tick(4);
    bus_read(32'h4, 32'h0, "key0_before_accept");
    bus_read(32'h4, 32'h1, "key0_accepted");
    note_press(4'b0001);
    bus_read(32'h8, 32'h1, "key0_event");
    check_pin(0, {28'b0, exp_led}, "led_after_key0");
    FPGA_Key = 4'hF;
    tick(8);
    bus_read(32'h4, 32'h0, "key0_released");
    bus_read(32'h8, 32'h1, "event_sticky_after_release");

    // glitches of 2 and 3 cycles on key 1
    FPGA_Key = 4'b1101;
    tick(2);
    FPGA_Key = 4'hF;
    tick(8);
    bus_read(32'h4, 32'h0, "glitch2_state");
    bus_read(32'h8, 32'h1, "glitch2_event");
    FPGA_Key = 4'b1101;
    tick(3);
    FPGA_Key = 4'hF;
    tick(8);
    bus_read(32'h4, 32'h0, "glitch3_state");
    bus_read(32'h8, 32'h1, "glitch3_event");

    // interrupt masking, W1C, enable timing
    bus_write(32'hC, 32'h2);
    check_pin(1, 0, "irq_masked_key0");
    FPGA_Key = 4'b1101;
    tick(10);
    note_press(4'b0010);
    check_pin(1, 1, "irq_key1");
    bus_read(32'h8, 32'h3, "event_key0_key1");
    FPGA_Key = 4'hF;
    tick(8);
    bus_write(32'h8, 32'h2);
    check_pin(1, 1, "irq_still_set_at_clear");
    check_pin(1, 0, "irq_cleared");
    bus_read(32'h8, 32'h1, "event_after_w1c");
    bus_write(32'hC, 32'h1);
    check_pin(1, 0, "irq_en_not_yet");
    check_pin(1, 1, "irq_en_following_cycle");
    bus_write(32'hC, 32'h0);

    // W1C coincident with a new press on key 2: set wins, bit 0 clears
    FPGA_Key = 4'b1011;
    tick(4);
    bus_write(32'h8, 32'h5);
    note_press(4'b0100);
    bus_read(32'h8, 32'h4, "w1c_vs_press_set_wins");
    FPGA_Key = 4'hF;
    tick(8);
    check_pin(0, {28'b0, exp_led}, "led_after_presses");

    // all keys together, then key 0 again
    bus_write(32'h0, 32'h0);
    exp_led = 4'h0;
    FPGA_Key = 4'h0;
    tick(10);
    note_press(4'hF);
    check_pin(0, {28'b0, exp_led}, "led_all_keys");
    bus_read(32'h4, 32'hF, "key_state_all");
    FPGA_Key = 4'hF;
    tick(8);
    FPGA_Key = 4'b1110;
    tick(10);
    note_press(4'b0001);
    check_pin(0, {28'b0, exp_led}, "led_key0_again");
    FPGA_Key = 4'hF;
    tick(8);

    // reset during the data phase of a write aborts it
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = 1'b1;
    bus.HADDR  = 32'h0;
    tick();
    idle_bus();
    bus.HWDATA = 32'h3;
    HRESET     = 1'b1;
    tick();
    HRESET = 1'b0;
    bus_read(32'h0, 32'h0, "led_after_reset_abort");
    bus_read(32'h8, 32'h0, "event_after_reset");
    check_pin(0, 0, "fpga_led_after_reset");

    tick(2);
    n_cmp++;
    if (rd_exp_q.size() != 0 || pin_exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queues_drained: %0d reads and %0d pin samples left, required 0",
               rd_exp_q.size(), pin_exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
